pool_stream_ctrl: RTL

//  Streaming sequencer for 2x2/stride-2 pooling of one NxN signed 16-bit feature map per frame.

---
 rtl/pool_stream_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pool_stream_ctrl.sv
// pool_stream_ctrl: streaming 2x2/stride-2 pooling sequencer for one NxN signed map per frame.
// Pixels arrive in raster order; even-row pair results wait in a line buffer until the odd row
// completes each window. Default build averages; define POOL_MAX_EN for max pooling.
module pool_stream_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned HW = (CW > 1) ? CW - 1 : 1;
  localparam int unsigned LD = 2 ** HW;
`ifdef POOL_MAX_EN
  localparam int unsigned LBW = W;
`else
  localparam int unsigned LBW = W + 1;
  localparam int unsigned SW  = W + 2;
`endif

  typedef enum logic [1:0] {IDLE, EVEN, ODD, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         col, row;
  logic signed [W-1:0]   hold;
  logic signed [LBW-1:0] linebuf [LD];
  logic [HW-1:0]         lb_idx;
  logic signed [LBW-1:0] pair_c;
  logic signed [W-1:0]   result_c;
  logic                  accept_c, col_last_c, row_last_c, out_fire_c, result_c_en;

  assign accept_c    = in_valid && in_ready;
  assign col_last_c  = (col == CW'(N - 1));
  assign row_last_c  = (row == CW'(N - 1));
  assign out_fire_c  = out_valid && out_ready;
  assign lb_idx      = HW'(col >> 1);
  assign result_c_en = accept_c && (state == ODD) && col[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = EVEN;
      EVEN:  if (accept_c && col_last_c) state_nxt = ODD;
      ODD:   if (accept_c && col_last_c) state_nxt = row_last_c ? DRAIN : EVEN;
      DRAIN: if (out_fire_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Input handshake: accept only while streaming and no unaccepted result is blocking
  always_comb begin
    in_ready = 1'b0;
    if ((state == EVEN) || (state == ODD)) in_ready = !(out_valid && !out_ready);
  end

  // Window arithmetic: pair of horizontally adjacent pixels, then combine with buffered pair
`ifdef POOL_MAX_EN
  always_comb begin
    pair_c   = (hold > $signed(in_data)) ? hold : $signed(in_data);
    result_c = (linebuf[lb_idx] > pair_c) ? linebuf[lb_idx] : pair_c;
  end
`else
  logic signed [SW-1:0] sum_c;
  always_comb begin
    pair_c   = LBW'(hold) + LBW'($signed(in_data));
    sum_c    = SW'(linebuf[lb_idx]) + SW'(pair_c);
    result_c = W'(sum_c >>> 2);
  end
`endif

  // Raster counters and even-column pixel hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col  <= '0;
      row  <= '0;
      hold <= '0;
    end else if ((state == IDLE) && start) begin
      col <= '0;
      row <= '0;
    end else if (accept_c) begin
      if (!col[0]) hold <= $signed(in_data);
      if (col_last_c) begin
        col <= '0;
        row <= row_last_c ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffer holds even-row pair results until the odd row reaches the same column pair
  always_ff @(posedge clk) begin
    if (accept_c && (state == EVEN) && col[0]) linebuf[lb_idx] <= pair_c;
  end

  // Output register plus busy/done status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (result_c_en) begin
        out_valid <= 1'b1;
        out_data  <= result_c;
      end else if (out_fire_c) begin
        out_valid <= 1'b0;
      end
      done <= (state == DRAIN) && out_fire_c;
      if ((state == IDLE) && start)            busy <= 1'b1;
      else if ((state == DRAIN) && out_fire_c) busy <= 1'b0;
    end
  end

endmodule
